sdm_tx: RTL and testbench

Digital second-order sigma-delta modulator and line transmitter that drives one SDFM input channel. Accepts signed PCM samples over a valid/ready handshake and produces a 1-bit density stream at a programmable modulator clock. Output is either a separate clock/data pair or a Manchester-coded single wire, matching SDFM input mode 2. Used as the stimulus source for demodulator benches and as a loopback transmitter on-chip.

---
 rtl/sdm_pkg.sv | 13 +
 rtl/sdm_tx_if.sv | 12 +
 rtl/sdm_clkgen.sv | 44 ++++
 rtl/sdm_tx.sv | 126 ++++++++++++
 tb/tb_sdm_tx.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdm_pkg.sv
// Shared constants for the sigma-delta transmitter: line-mode encodings and
// the integrator saturation bound.
package sdm_pkg;

  localparam logic MODE_CLKDATA = 1'b0;
  localparam logic MODE_MANCH   = 1'b1;

  // Integrators are DW+4 bits wide; clamp symmetrically one LSB inside full scale.
  function automatic int sat_limit(input int dw);
    return (1 << (dw + 3)) - 1;
  endfunction

endpackage

// File: rtl/sdm_tx_if.sv
// Sample handshake into the modulator: producer drives SAMPLE/SVALID, the
// transmitter answers with SREADY.
interface sdm_tx_if #(
  parameter int DW = 16
);
  logic signed [DW-1:0] SAMPLE;
  logic                 SVALID;
  logic                 SREADY;

  modport master (output SAMPLE, output SVALID, input SREADY);
  modport slave  (input SAMPLE, input SVALID, output SREADY);
endinterface

// File: rtl/sdm_clkgen.sv
// Modulator clock divider: sck toggles every CLKDIV+1 cycles while enabled,
// and each falling toggle of sck is reported as a bit tick.
module sdm_clkgen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DIVW-1:0] clkdiv,
  output logic            sck_d,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            sck_q;

  // Wrapping on >= keeps the divider live if CLKDIV is lowered mid-count.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (cnt_q >= clkdiv) begin
      cnt_d = '0;
      sck_d = ~sck_q;
      tick  = sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/sdm_tx.sv
// Second-order 1-bit sigma-delta modulator with clock+data or Manchester
// line output, fed by a one-deep sample holding register.
module sdm_tx
  import sdm_pkg::*;
#(
  parameter int DW   = 16,
  parameter int DIVW = 8
) (
  input  logic            EXTCLK,
  input  logic            EXTRST,
  input  logic            EN,
  input  logic            MODE,
  input  logic [DIVW-1:0] CLKDIV,
  sdm_tx_if.slave         s,
  output logic            SDCLK,
  output logic            SDO,
  output logic            BITSTB,
  output logic            OVF
);

  localparam int AW = DW + 4;
  // Two guard bits so the unclamped sums never wrap before saturation.
  localparam int SW = DW + 6;
  localparam logic signed [SW-1:0] LIM    = SW'(sat_limit(DW));
  localparam logic signed [SW-1:0] FB_MAG = SW'(2 ** (DW - 1));

  logic sck_d, tick;

  sdm_clkgen #(.DIVW(DIVW)) u_clkgen (
    .clk    (EXTCLK),
    .rst    (EXTRST),
    .en     (EN),
    .clkdiv (CLKDIV),
    .sck_d  (sck_d),
    .tick   (tick)
  );

  logic signed [DW-1:0] hold_q, hold_d, act_q, act_d, act_use;
  logic signed [AW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic signed [SW-1:0] fb, sum1, sum2, i1_new, i2_new;
  logic pend_q, pend_d, bit_q, bit_d, sready_q, sready_d;
  logic sdclk_q, sdclk_d, sdo_q, sdo_d, bitstb_q, bitstb_d, ovf_q, ovf_d;
  logic accept, clip1, clip2;

  always_comb begin
    accept  = s.SVALID && !pend_q;
    // A pending sample is consumed by the very tick that transfers it.
    act_use = pend_q ? hold_q : act_q;
    fb      = bit_q ? FB_MAG : -FB_MAG;

    sum1   = SW'(i1_q) + SW'(act_use) - fb;
    clip1  = (sum1 > LIM) || (sum1 < -LIM);
    i1_new = (sum1 > LIM) ? LIM : ((sum1 < -LIM) ? -LIM : sum1);
    sum2   = SW'(i2_q) + i1_new - fb;
    clip2  = (sum2 > LIM) || (sum2 < -LIM);
    i2_new = (sum2 > LIM) ? LIM : ((sum2 < -LIM) ? -LIM : sum2);

    hold_d = hold_q;
    pend_d = pend_q;
    act_d  = act_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    bit_d  = bit_q;
    ovf_d  = 1'b0;

    if (tick) begin
      if (pend_q) begin
        act_d  = hold_q;
        pend_d = 1'b0;
      end
      i1_d  = i1_new[AW-1:0];
      i2_d  = i2_new[AW-1:0];
      bit_d = ~i2_new[SW-1];
      ovf_d = clip1 || clip2;
    end
    if (accept) begin
      hold_d = s.SAMPLE;
      pend_d = 1'b1;
    end
    if (!EN) begin
      i1_d  = '0;
      i2_d  = '0;
      bit_d = 1'b0;
    end

    sready_d = !pend_d;
    sdclk_d  = EN && (MODE == MODE_CLKDATA) && sck_d;
    sdo_d    = EN && ((MODE == MODE_MANCH) ? (bit_d ^ sck_d) : bit_d);
    bitstb_d = tick;
  end

  always_ff @(posedge EXTCLK or posedge EXTRST) begin
    if (EXTRST) begin
      hold_q   <= '0;
      pend_q   <= 1'b0;
      act_q    <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      bit_q    <= 1'b0;
      sready_q <= 1'b1;
      sdclk_q  <= 1'b0;
      sdo_q    <= 1'b0;
      bitstb_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      bit_q    <= bit_d;
      sready_q <= sready_d;
      sdclk_q  <= sdclk_d;
      sdo_q    <= sdo_d;
      bitstb_q <= bitstb_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s.SREADY = sready_q;
  assign SDCLK    = sdclk_q;
  assign SDO      = sdo_q;
  assign BITSTB   = bitstb_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_sdm_tx.sv
// Self-checking bench for sdm_tx: vector table of density runs, hand-written
// handshake/saturation/reset sequences and a randomized segment.
module tb_sdm_tx;

  localparam int DW   = 16;
  localparam int DIVW = 8;
  localparam int LIM  = (1 << (DW + 3)) - 1;
  localparam int HALF = 1 << (DW - 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            mode = 1'b0;
  logic [DIVW-1:0] clkdiv = '0;
  logic            sdclk, sdo, bitstb, ovf;

  sdm_tx_if #(.DW(DW)) sif ();

  sdm_tx #(.DW(DW), .DIVW(DIVW)) dut (
    .EXTCLK (clk),
    .EXTRST (rst),
    .EN     (en),
    .MODE   (mode),
    .CLKDIV (clkdiv),
    .s      (sif),
    .SDCLK  (sdclk),
    .SDO    (sdo),
    .BITSTB (bitstb),
    .OVF    (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: bit period derived from the cycle count since enable,
  // accepted samples in a queue, integrators as plain integers.
  int m_t, m_i1, m_i2, m_bit, m_act;
  int m_q[$];

  int errors = 0, checks = 0;
  int mism = 0;
  string first_msg = "";
  int cyc = 0, ones = 0, bits_seen = 0, ovf_seen = 0;
  int last_stb = -1, last_period = 0, fall_bad = 0;
  logic prev_sdclk = 1'b0;
  int bitlog[$];
  int ref0[$];

  typedef struct {
    logic mode;
    int   div;
    int   sample;
    int   nbits;
    int   lo;
    int   hi;
  } vec_t;
  vec_t vt[6];

  function automatic int clampv(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_i1 = 0; m_i2 = 0; m_bit = 0; m_act = 0;
    m_q.delete();
    prev_sdclk = 1'b0;
    last_stb = -1;
  endtask

  task automatic chk(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end else begin
      $display("check %s: got %0d ok", name, got);
    end
  endtask

  task automatic chk_stream(input string name);
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s: %0d cycle mismatches, required 0; first %s", name, mism, first_msg);
    end else begin
      $display("check %s: stream matches model", name);
    end
    mism = 0;
    first_msg = "";
  endtask

  task automatic cycle(output bit fired);
    bit   en_c, mode_c, acc, tick, clip;
    int   d, sck, fb, samp_c, v;
    logic [4:0] exp_v, got_v;
    en_c   = en;
    mode_c = mode;
    d      = int'(clkdiv) + 1;
    samp_c = int'(sif.SAMPLE);
    fired  = sif.SVALID && sif.SREADY;
    acc    = sif.SVALID && (m_q.size() == 0);
    @(posedge clk);
    #1;
    cyc++;
    tick = 1'b0;
    clip = 1'b0;
    sck  = 0;
    if (en_c) begin
      m_t++;
      tick = (m_t % (2 * d)) == 0;
      sck  = (m_t / d) % 2;
    end else begin
      m_t = 0;
    end
    if (tick) begin
      if (m_q.size() > 0) m_act = m_q.pop_front();
      fb = (m_bit != 0) ? HALF : -HALF;
      v = m_i1 + m_act - fb;
      if (clampv(v) != v) clip = 1'b1;
      m_i1 = clampv(v);
      v = m_i2 + m_i1 - fb;
      if (clampv(v) != v) clip = 1'b1;
      m_i2 = clampv(v);
      m_bit = (m_i2 >= 0) ? 1 : 0;
    end
    if (!en_c) begin
      m_i1 = 0; m_i2 = 0; m_bit = 0;
    end
    if (acc) m_q.push_back(samp_c);
    exp_v[4] = (m_q.size() == 0);
    exp_v[3] = en_c && !mode_c && (sck != 0);
    exp_v[2] = en_c && (mode_c ? ((m_bit ^ sck) != 0) : (m_bit != 0));
    exp_v[1] = tick;
    exp_v[0] = tick && clip;
    got_v = {sif.SREADY, sdclk, sdo, bitstb, ovf};
    if (got_v !== exp_v) begin
      if (mism == 0)
        first_msg = $sformatf("cyc %0d {rdy,sdclk,sdo,stb,ovf} got %b exp %b", cyc, got_v, exp_v);
      mism++;
    end
    if (bitstb === 1'b1) begin
      bits_seen++;
      ones += (sdo === 1'b1) ? 1 : 0;
      bitlog.push_back((sdo === 1'b1) ? 1 : 0);
      if (last_stb >= 0) last_period = cyc - last_stb;
      last_stb = cyc;
      if (!mode_c && !(prev_sdclk === 1'b1 && sdclk === 1'b0)) fall_bad++;
    end
    if (ovf === 1'b1) ovf_seen++;
    prev_sdclk = sdclk;
  endtask

  task automatic tick1();
    bit f;
    cycle(f);
  endtask

  task automatic do_reset();
    en = 1'b0;
    sif.SVALID = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input int v, input string name);
    bit f;
    int k;
    sif.SAMPLE = DW'(v);
    sif.SVALID = 1'b1;
    f = 1'b0;
    k = 0;
    while (!f && k < 200) begin
      cycle(f);
      k++;
    end
    sif.SVALID = 1'b0;
    if (!f) chk({name, "_accept_timeout"}, k, 0, 199);
  endtask

  task automatic run_bits(input int n, input string name);
    int target, bound, k;
    target = bits_seen + n;
    bound  = (n + 2) * 2 * (int'(clkdiv) + 1) + 8;
    k = 0;
    while (bits_seen < target && k < bound) begin
      tick1();
      k++;
    end
    if (bits_seen < target) chk({name, "_bit_timeout"}, bits_seen - target + n, n, n);
  endtask

  initial begin
    int diff, k;
    bit f;
    sif.SVALID = 1'b0;
    sif.SAMPLE = '0;

    vt[0] = '{1'b0, 1,      0, 1024, 508, 516};
    vt[1] = '{1'b0, 0,  16384, 1024, 760, 776};
    vt[2] = '{1'b0, 2, -16384, 1024, 248, 264};
    vt[3] = '{1'b1, 1,      0, 1024, 508, 516};
    vt[4] = '{1'b1, 0,  16384, 1024, 760, 776};
    vt[5] = '{1'b1, 2, -16384, 1024, 248, 264};

    #2;
    do_reset();
    chk("reset_sready", int'(sif.SREADY), 1, 1);
    chk("reset_sdclk", int'(sdclk), 0, 0);
    chk("reset_sdo", int'(sdo), 0, 0);
    chk("reset_bitstb", int'(bitstb), 0, 0);
    chk("reset_ovf", int'(ovf), 0, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      mode   = vt[i].mode;
      clkdiv = DIVW'(vt[i].div);
      send(vt[i].sample, "vec");
      en = 1'b1;
      ones = 0;
      bits_seen = 0;
      fall_bad = 0;
      bitlog.delete();
      run_bits(vt[i].nbits, $sformatf("vec%0d", i));
      chk_stream($sformatf("vec%0d_stream", i));
      chk($sformatf("vec%0d_ones", i), ones, vt[i].lo, vt[i].hi);
      if (!vt[i].mode) begin
        chk($sformatf("vec%0d_bit_period", i), last_period, 2 * (vt[i].div + 1), 2 * (vt[i].div + 1));
        chk($sformatf("vec%0d_stb_on_fall", i), fall_bad, 0, 0);
      end
      if (i == 0) ref0 = bitlog;
      if (i == 3) begin
        diff = (ref0.size() == bitlog.size()) ? 0 : 1000000;
        for (int j = 0; j < ref0.size() && j < bitlog.size(); j++)
          if (ref0[j] != bitlog[j]) diff++;
        chk("manch_matches_clkdata", diff, 0, 0);
      end
    end

    // Back-to-back samples: the second waits for the next tick.
    do_reset();
    mode = 1'b0;
    clkdiv = DIVW'(3);
    en = 1'b1;
    repeat (3) tick1();
    send(20000, "hs_first");
    chk("hs_busy_after_first", int'(sif.SREADY), 0, 0);
    sif.SAMPLE = DW'(-20000);
    sif.SVALID = 1'b1;
    k = 0;
    while (sif.SREADY !== 1'b1 && k < 40) begin
      tick1();
      k++;
    end
    chk("hs_ready_with_tick", int'(bitstb), 1, 1);
    cycle(f);
    sif.SVALID = 1'b0;
    chk("hs_second_accepted", int'(f), 1, 1);
    chk("hs_second_pending", int'(sif.SREADY), 0, 0);
    run_bits(40, "hs");
    chk_stream("hs_stream");

    // Full-scale input drives the integrators into saturation, then recovers.
    do_reset();
    mode = 1'b0;
    clkdiv = '0;
    send(32767, "sat");
    en = 1'b1;
    ones = 0;
    bits_seen = 0;
    ovf_seen = 0;
    run_bits(4096, "sat");
    chk("sat_ones", ones, 4056, 4096);
    chk("sat_ovf_pulses", ovf_seen, 1, 1000000);
    send(0, "recover");
    run_bits(64, "recover_settle");
    ones = 0;
    run_bits(1024, "recover");
    chk("recover_ones", ones, 502, 522);
    chk_stream("sat_stream");

    // Asynchronous reset mid-bit while a sample is pending.
    do_reset();
    mode = 1'b0;
    clkdiv = DIVW'(2);
    en = 1'b1;
    bits_seen = 0;
    run_bits(3, "rst_pre");
    send(12345, "rst_pend");
    chk("rst_pend_busy", int'(sif.SREADY), 0, 0);
    chk_stream("rst_pre_stream");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'({sdclk, sdo, bitstb, ovf}), 0, 0);
    chk("rst_async_sready", int'(sif.SREADY), 1, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_bits(30, "rst_post");
    chk_stream("rst_post_stream");

    // Randomized segments: mode/divider change only while disabled.
    do_reset();
    for (int seg = 0; seg < 16; seg++) begin
      en = 1'b0;
      mode = 1'($urandom_range(0, 1));
      clkdiv = DIVW'($urandom_range(0, 3));
      for (int j = 0; j < 40 + int'($urandom_range(0, 80)); j++) begin
        sif.SVALID = 1'($urandom_range(0, 1));
        sif.SAMPLE = DW'(int'($urandom_range(0, 40000)) - 20000);
        if (j == 2) en = 1'b1;
        tick1();
      end
    end
    sif.SVALID = 1'b0;
    chk_stream("random_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
